// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants, load/store encodings and memory-stage state type
package core_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;
endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed lane of a read word and sign/zero-extends it
module load_align (
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  import core_pkg::*;

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_funct3)
      F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_data = {24'h000000, w_shifted[7:0]};
      F3_HU:   o_data = {16'h0000, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end
endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RISC-V memory stage: issues data-memory accesses, aligns loads,
// and registers the writeback bundle
module mem_access_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            InValid,
  input  logic [XLEN-1:0] ALUOut,
  input  logic [XLEN-1:0] StoreData,
  input  logic [2:0]      Funct3,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            RegWriteE,
  input  logic [RD_W-1:0] RdE,
  output logic            StallM,
  output logic            MemReq,
  output logic            MemWe,
  output logic [XLEN-1:0] MemAddr,
  output logic [XLEN-1:0] MemWData,
  output logic [3:0]      MemBe,
  input  logic            MemReady,
  input  logic [XLEN-1:0] MemRData,
  output logic            WbValid,
  output logic [XLEN-1:0] WbResult,
  output logic [RD_W-1:0] WbRd,
  output logic            WbRegWrite,
  output logic            LsuErr,
  output logic [XLEN-1:0] LsuErrAddr
);
  import core_pkg::*;

  state_t          r_state, w_next;
  logic [XLEN-1:0] r_mem_addr, r_mem_wdata, r_wb_result, r_err_addr;
  logic [3:0]      r_mem_be;
  logic            r_mem_we, r_wb_valid, r_wb_regwrite, r_lsu_err, r_lat_regwrite;
  logic [RD_W-1:0] r_wb_rd, r_lat_rd;
  logic [1:0]      r_lat_off;
  logic [2:0]      r_lat_f3;

  logic            w_accept, w_mem_op, w_illegal, w_misaligned, w_err, w_start, w_done;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata, w_load_data;

  assign w_mem_op     = MemRead | MemWrite;
  assign w_illegal    = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11) ||
                        (MemWrite && (Funct3 == F3_BU || Funct3 == F3_HU));
  assign w_misaligned = (Funct3[1:0] == 2'b01 && ALUOut[0]) ||
                        (Funct3[1:0] == 2'b10 && ALUOut[1:0] != 2'b00);
  assign w_accept     = (r_state == ST_IDLE) && InValid;
  assign w_err        = w_accept && w_mem_op && (w_illegal || w_misaligned);
  assign w_start      = w_accept && w_mem_op && !w_err;
  assign w_done       = (r_state == ST_ACCESS) && MemReady;

  // Lane placement uses the size bits only; BU/HU loads share B/H enables.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = StoreData;
    case (Funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALUOut[1:0];
        w_wdata = {4{StoreData[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << ALUOut[1:0];
        w_wdata = {2{StoreData[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_next = ST_ACCESS;
      ST_ACCESS: if (MemReady) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    StallM = (r_state == ST_ACCESS);
    MemReq = (r_state == ST_ACCESS);
  end

  load_align u_load_align (
    .i_rdata  (MemRData),
    .i_off    (r_lat_off),
    .i_funct3 (r_lat_f3),
    .o_data   (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_be       <= '0;
      r_mem_we       <= 1'b0;
      r_lat_off      <= '0;
      r_lat_f3       <= '0;
      r_lat_rd       <= '0;
      r_lat_regwrite <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_result    <= '0;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
      r_lsu_err      <= 1'b0;
      r_err_addr     <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_lsu_err  <= 1'b0;
      if (w_start) begin
        r_mem_addr     <= {ALUOut[XLEN-1:2], 2'b00};
        r_mem_wdata    <= w_wdata;
        r_mem_be       <= w_be;
        r_mem_we       <= MemWrite;
        r_lat_off      <= ALUOut[1:0];
        r_lat_f3       <= Funct3;
        r_lat_rd       <= RdE;
        r_lat_regwrite <= RegWriteE;
      end
      if (w_err) begin
        r_lsu_err  <= 1'b1;
        r_err_addr <= ALUOut;
      end
      // Non-memory ops and faulting accesses retire straight from IDLE.
      if (w_accept && !w_start) begin
        r_wb_valid    <= 1'b1;
        r_wb_rd       <= RdE;
        r_wb_result   <= w_err ? '0 : ALUOut;
        r_wb_regwrite <= !w_err && RegWriteE && (RdE != '0);
      end
      if (w_done) begin
        r_wb_valid    <= 1'b1;
        r_wb_rd       <= r_lat_rd;
        r_wb_result   <= r_mem_we ? '0 : w_load_data;
        r_wb_regwrite <= !r_mem_we && r_lat_regwrite && (r_lat_rd != '0);
      end
    end
  end

  assign MemWe      = r_mem_we;
  assign MemAddr    = r_mem_addr;
  assign MemWData   = r_mem_wdata;
  assign MemBe      = r_mem_be;
  assign WbValid    = r_wb_valid;
  assign WbResult   = r_wb_result;
  assign WbRd       = r_wb_rd;
  assign WbRegWrite = r_wb_regwrite;
  assign LsuErr     = r_lsu_err;
  assign LsuErrAddr = r_err_addr;
endmodule
